// File: rtl/lfsr_multistep_if.sv
// Control/data bundle between a bus-side requester and the multistep LFSR.
// Latency: none; pure signal grouping.
// Backpressure: skip requests handshake on skip_valid/skip_ready; other controls are fire-and-forget.
interface lfsr_multistep_if #(
  parameter int WIDTH = 32,
  parameter int SLOTS = 2
);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic              e;
  logic              save;
  logic              restore;
  logic [SLOT_W-1:0] slot;
  logic              load_state;
  logic              load_mask;
  logic [WIDTH-1:0]  load_data;
  logic              skip_valid;
  logic [15:0]       skip_count;
  logic              skip_ready;
  logic              skip_done;
  logic              stuck;
  logic [WIDTH-1:0]  q;

  modport master (
    output e, save, restore, slot, load_state, load_mask, load_data,
           skip_valid, skip_count,
    input  skip_ready, skip_done, stuck, q
  );

  modport slave (
    input  e, save, restore, slot, load_state, load_mask, load_data,
           skip_valid, skip_count,
    output skip_ready, skip_done, stuck, q
  );
endinterface

// File: rtl/lfsr_multistep.sv
// XNOR Fibonacci LFSR with loadable mask/state, save/restore slots, skip-ahead engine and lock-up reseed.
// Latency: q updates one cycle after an action; a skip of N advances occupies N cycles, skip_done the cycle after.
// Backpressure: skip_ready is low while a skip runs; e/restore/load_state/skip_valid are ignored then.
module lfsr_multistep #(
  parameter int              WIDTH = 32,
  parameter int              STEP  = 1,
  parameter int              SLOTS = 2,
  parameter logic [31:0]     SEED  = 32'h075BCD15,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h80200003)
) (
  input logic              clk,
  input logic              reset_n,
  lfsr_multistep_if.slave  bus
);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  // The 32-bit seed is tiled LSB-first so wide instances still get a non-trivial reset state.
  function automatic logic [WIDTH-1:0] f_ext_seed();
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[i] = SEED[i % 32];
    return v;
  endfunction

  localparam logic [WIDTH-1:0] SEED_EXT = f_ext_seed();

  // One advance: STEP chained XNOR shifts, or a reseed when sitting in the lock-up state.
  function automatic logic [WIDTH-1:0] f_advance(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] v;
    if ((&s) && (~^m)) begin
      v = SEED_EXT;
    end else begin
      v = s;
      for (int k = 0; k < STEP; k++) v = {v[WIDTH-2:0], ~^(v & m)};
    end
    return v;
  endfunction

  typedef enum logic [0:0] {S_IDLE, S_SKIP} fsm_t;

  fsm_t             r_fsm;
  logic [15:0]      r_rem;
  logic             r_done;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_slot [SLOTS];

  fsm_t             w_nxt_fsm;
  logic [15:0]      w_nxt_rem;
  logic             w_nxt_done;
  logic [WIDTH-1:0] w_nxt_state;
  logic [WIDTH-1:0] w_nxt_mask;
  logic [WIDTH-1:0] w_adv;
  logic [WIDTH-1:0] w_slot_rd;
  logic             w_slot_ok;

  // Feedback always uses the registered mask, so a same-cycle load_mask only affects later advances.
  assign w_adv = f_advance(r_state, r_mask);

  // Decode the slot index; out-of-range indices leave w_slot_ok low so save/restore become no-ops.
  always_comb begin
    w_slot_ok = 1'b0;
    w_slot_rd = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (bus.slot == SLOT_W'(i)) begin
        w_slot_ok = 1'b1;
        w_slot_rd = r_slot[i];
      end
    end
  end

  // Next-state: IDLE takes one of restore > load_state > e and may accept a skip; SKIP advances once per cycle.
  always_comb begin
    w_nxt_fsm   = r_fsm;
    w_nxt_rem   = r_rem;
    w_nxt_done  = 1'b0;
    w_nxt_state = r_state;
    w_nxt_mask  = bus.load_mask ? bus.load_data : r_mask;
    case (r_fsm)
      S_IDLE: begin
        if (bus.restore && w_slot_ok) w_nxt_state = w_slot_rd;
        else if (bus.load_state)      w_nxt_state = bus.load_data;
        else if (bus.e)               w_nxt_state = w_adv;
        if (bus.skip_valid) begin
          if (bus.skip_count == 16'd0) begin
            w_nxt_done = 1'b1;
          end else begin
            w_nxt_fsm = S_SKIP;
            w_nxt_rem = bus.skip_count;
          end
        end
      end
      S_SKIP: begin
        w_nxt_state = w_adv;
        w_nxt_rem   = r_rem - 16'd1;
        if (r_rem == 16'd1) begin
          w_nxt_fsm  = S_IDLE;
          w_nxt_done = 1'b1;
        end
      end
      default: w_nxt_fsm = S_IDLE;
    endcase
  end

  // FSM, LFSR state and mask registers; reset abandons any skip without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm   <= S_IDLE;
      r_rem   <= 16'd0;
      r_done  <= 1'b0;
      r_state <= SEED_EXT;
      r_mask  <= TAPS;
    end else begin
      r_fsm   <= w_nxt_fsm;
      r_rem   <= w_nxt_rem;
      r_done  <= w_nxt_done;
      r_state <= w_nxt_state;
      r_mask  <= w_nxt_mask;
    end
  end

  // Save captures the pre-update state in any FSM state; a same-cycle restore has already read the old slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SLOTS; i++) r_slot[i] <= SEED_EXT;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (bus.save && (bus.slot == SLOT_W'(i))) r_slot[i] <= r_state;
      end
    end
  end

  assign bus.q          = r_state;
  assign bus.stuck      = (&r_state) && (~^r_mask);
  assign bus.skip_ready = (r_fsm == S_IDLE);
  assign bus.skip_done  = r_done;
endmodule
